cmd_deframer: RTL

CMD_DEFRAMER -- requirements
Module: cmd_deframer

---
 rtl/cmd_deframer.sv | 117 +++++++++++
 1 files changed

// File: rtl/cmd_deframer.sv
// Two-byte command deframer behind a UART receiver, with an inter-byte timeout.
// Optional third checksum byte per frame: define CMD_DEFRAMER_CHKSUM_EN.
module cmd_deframer #(
    parameter int unsigned TIMEOUT_CYCLES = 26040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_err
);

`ifdef CMD_DEFRAMER_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, HIGH, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH} state_t;
`endif

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        acc_q, acc_d;
    logic [15:0] tmo_q, tmo_d;
    logic        accept;
    logic        tmo_hit;
`ifdef CMD_DEFRAMER_CHKSUM_EN
    logic [7:0]  cksum;
`endif

    // rx_rdy stays high for a clock after our clear; the previous-accept flag masks it
    assign accept  = rx_rdy & ~acc_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
        frm_err_d = 1'b0;
        acc_d     = accept;
        tmo_d     = '0;
`ifdef CMD_DEFRAMER_CHKSUM_EN
        cksum     = ~(cmd_q[15:8] + cmd_q[7:0]);
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d[15:8] = rx_data;
                    cmd_rdy_d   = 1'b0;
                    state_d     = HIGH;
                end
            end
            HIGH: begin
                if (accept) begin
                    cmd_d[7:0] = rx_data;
`ifdef CMD_DEFRAMER_CHKSUM_EN
                    state_d    = CHK;
`else
                    state_d    = IDLE;
                    cmd_rdy_d  = 1'b1;
`endif
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    frm_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`ifdef CMD_DEFRAMER_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = IDLE;
                    if (rx_data == cksum) cmd_rdy_d = 1'b1;
                    else                  frm_err_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    frm_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
            acc_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
        end
    end

    // Gated by rst_n so the clear pulse is also held low while in reset
    assign clr_rx_rdy = accept & rst_n;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign frm_err    = frm_err_q;

endmodule
